systolic_row_collector: RTL and testbench

Downstream stage of the backprop systolic array. Takes the skewed accumulated output stream `acc_z_to_z` and removes the skew: lane k arrives k cycles after lane 0. It then assembles aligned rows of `size` Q8.8 words and buffers them in a row FIFO with a valid/ready output. The block also keeps a row counter and a sticky overflow flag for the layer sequencer.

---
 rtl/systolic_row_collector.sv | 161 ++++++++++++++++
 tb/tb_systolic_row_collector.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_row_collector.sv
// Deskews the systolic array's staggered accumulator stream into aligned rows
// and buffers them in a show-ahead row FIFO with valid/ready handshake.
module systolic_row_collector #(
  parameter int data_size = 16,
  parameter int size      = 3,
  parameter int depth     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [data_size*size-1:0]     acc_in,
  input  logic                          in_valid,
  input  logic                          clear,
  output logic [data_size*size-1:0]     out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(depth+1)-1:0]    level,
  output logic [15:0]                   row_count,
  output logic                          overflow
);

  localparam int ROW_W = data_size * size;
  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(depth - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  logic [ROW_W-1:0] aligned_row_s;
  logic [size-2:0]  vld_q, vld_d;
  logic             row_valid_s;

  // Lane k is delayed size-1-k cycles so every lane lines up with the last one.
  for (genvar k = 0; k < size - 1; k++) begin : g_lane
    localparam int L = size - 1 - k;
    logic [data_size-1:0] chain_q [L];
    logic [data_size-1:0] chain_d [L];

    always_comb begin
      chain_d[0] = acc_in[data_size*(size-k)-1 -: data_size];
      for (int i = 1; i < L; i++) begin
        chain_d[i] = chain_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < L; i++) begin
          chain_q[i] <= '0;
        end
      end else begin
        chain_q <= chain_d;
      end
    end

    assign aligned_row_s[data_size*(size-k)-1 -: data_size] = chain_q[L-1];
  end

  assign aligned_row_s[data_size-1:0] = acc_in[data_size-1:0];

  always_comb begin
    if (clear) begin
      vld_d = '0;
    end else begin
      vld_d    = vld_q << 1;
      vld_d[0] = in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign row_valid_s = vld_q[size-2];

  logic [ROW_W-1:0] mem_q [depth];
  logic [ROW_W-1:0] mem_d [depth];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      row_count_q, row_count_d;
  logic             overflow_q, overflow_d;
  logic             pop_s, full_s, push_ok_s, drop_s;

  always_comb begin
    pop_s     = (count_q != '0) & out_ready;
    full_s    = (count_q == CNT_W'(depth));
    push_ok_s = row_valid_s & (~full_s | pop_s);
    drop_s    = row_valid_s & full_s & ~pop_s;
  end

  // A pop frees the head slot, so a full FIFO still accepts a concurrent push.
  always_comb begin
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    row_count_d = row_count_q;
    overflow_d  = overflow_q;
    if (clear) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      row_count_d = 16'd0;
      overflow_d  = 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = aligned_row_s;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
        row_count_d     = row_count_q + 16'd1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      overflow_d = overflow_q | drop_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      row_count_q <= 16'd0;
      overflow_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      row_count_q <= row_count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign level     = count_q;
  assign row_count = row_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_systolic_row_collector.sv
// Bench for systolic_row_collector: directed scenarios plus random traffic,
// checked every cycle against a queue-based row model.
module tb_systolic_row_collector;

  localparam int W     = 16;
  localparam int S     = 3;
  localparam int D     = 4;
  localparam int RW    = W * S;
  localparam int CW    = $clog2(D + 1);
  localparam int NHIST = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] acc_in = '0;
  logic          in_valid = 1'b0;
  logic          clear = 1'b0;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] level;
  logic [15:0]   row_count;
  logic          overflow;

  systolic_row_collector #(.data_size(W), .size(S), .depth(D)) dut (
    .clk(clk), .rst_n(rst_n), .acc_in(acc_in), .in_valid(in_valid),
    .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .row_count(row_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Row written by the array in each cycle; lane k of it appears k cycles later.
  logic [RW-1:0] hist [NHIST];
  logic          vld_h [NHIST];
  int            cyc = 0;

  logic [RW-1:0] mq [$];
  logic [15:0]   m_rc = 16'd0;
  logic          m_ov = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rnd_row();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  task automatic step(input logic v, input logic rdy, input logic clr,
                      input logic rst, input logic [RW-1:0] row);
    int src;
    int al;
    int cnt;
    bit pop;
    hist[cyc]  = row;
    vld_h[cyc] = v;
    for (int k = 0; k < S; k++) begin
      src = cyc - k;
      if (src >= 0) acc_in[W*(S-k)-1 -: W] = hist[src][W*(S-k)-1 -: W];
      else acc_in[W*(S-k)-1 -: W] = 16'($urandom);
    end
    in_valid  = v;
    out_ready = rdy;
    clear     = clr;
    rst_n     = ~rst;
    #1;
    if (rst) begin
      mq.delete();
      m_rc = 16'd0;
      m_ov = 1'b0;
      for (int i = 0; i <= cyc; i++) vld_h[i] = 1'b0;
    end
    check_eq("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check_eq("level", 64'(level), 64'(mq.size()));
    check_eq("row_count", 64'(row_count), 64'(m_rc));
    check_eq("overflow", 64'(overflow), 64'(m_ov));
    if (mq.size() != 0) check_eq("out_data", 64'(out_data), 64'(mq[0]));
    else if (rst) check_eq("out_data_rst", 64'(out_data), 64'd0);
    if (!rst) begin
      al  = cyc - (S - 1);
      cnt = mq.size();
      pop = (cnt > 0) && rdy;
      if (clr) begin
        mq.delete();
        m_rc = 16'd0;
        m_ov = 1'b0;
        for (int i = (al < 0 ? 0 : al); i <= cyc; i++) vld_h[i] = 1'b0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (al >= 0 && vld_h[al]) begin
          if (cnt < D || pop) begin
            mq.push_back(hist[al]);
            m_rc = m_rc + 16'd1;
          end else begin
            m_ov = 1'b1;
          end
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, 1'b0, rnd_row());
  endtask

  task automatic push_rows(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, rdy, 1'b0, 1'b0, rnd_row());
  endtask

  initial begin
    logic [RW-1:0] r;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(3, 1'b0);

    // single row with the fixed lane values
    r = {16'h0100, 16'h0200, 16'h0300};
    step(1'b1, 1'b1, 1'b0, 1'b0, r);
    idle(5, 1'b1);

    // back-to-back rows, consumer always ready
    for (int n = 0; n < 5; n++) begin
      r = {16'(n), 16'(n + 16'h10), 16'(n + 16'h20)};
      step(1'b1, 1'b1, 1'b0, 1'b0, r);
    end
    idle(6, 1'b1);

    // overflow: fifth row dropped, then drain
    push_rows(5, 1'b0);
    idle(3, 1'b0);
    check_eq("ovf_level", 64'(level), 64'd4);
    check_eq("ovf_flag", 64'(overflow), 64'd1);
    idle(6, 1'b1);

    // reset clears the sticky flag and counters
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
    idle(2, 1'b0);

    // full FIFO with simultaneous push and pop
    push_rows(4, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, rnd_row());
    idle(1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, rnd_row());
    check_eq("fpp_level", 64'(level), 64'd4);
    check_eq("fpp_ovf", 64'(overflow), 64'd0);
    idle(6, 1'b1);

    // reset while a row is still arriving
    step(1'b1, 1'b0, 1'b0, 1'b0, rnd_row());
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
    idle(5, 1'b1);
    check_eq("rst_mid_valid", 64'(out_valid), 64'd0);

    // clear with two rows stored, overflow set, and a row aligning
    push_rows(5, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, rnd_row());
    idle(1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, rnd_row());
    check_eq("clr_level", 64'(level), 64'd0);
    check_eq("clr_rc", 64'(row_count), 64'd0);
    idle(4, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic v, rdy, clr, rst;
      clr = ($urandom_range(99) < 2);
      rst = !clr && ($urandom_range(199) < 1);
      v   = !clr && !rst && ($urandom_range(99) < 60);
      rdy = ($urandom_range(99) < 50);
      step(v, rdy, clr, rst, rnd_row());
    end
    idle(8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
